level_loader: RTL and testbench

Upstream feeder for `game_logic`: on request, copies one 10×10 level from a synchronous level ROM into the object memory and derives the cowboy start position from the field scan. It writes that position to addresses 100/101, where `game_logic` expects it. It then generates the periodic `next_screen` frame tick that drives `game_logic`. The top level gives this block the object-memory write port while `busy` is high, and gives it to `game_logic` otherwise.

---
 rtl/level_loader.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_level_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/level_loader.sv
// level_loader
//
// Upstream feeder for game_logic. On a start request it copies one 10x10
// level (100 field words) from a synchronous level ROM into object memory,
// scans the fields for the cowboy, then writes the cowboy row and column to
// object-memory addresses 100 and 101. After the load it emits a periodic
// one-cycle next_screen tick every TICK_DIV clocks.
//
// Optional feature macro: LEVEL_CHECK_EN
//   defined   - the level is validated: exactly one cowboy, and the box count
//               equals the goal count. A failing level raises level_error and
//               never ticks.
//   undefined - no validation; level_error is tied 0 and ticks always run.
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   start            single-cycle load request (honoured in idle and run only)
//   level_sel        level number, sampled together with start
//   rom_addr         level ROM address {level, idx[6:0]}
//   rom_data         ROM word, valid the cycle after rom_addr
//   address_write_om object-memory write address (120 when parked)
//   data_write_om    object-memory write data
//   wren             object-memory write enable
//   busy             high while this block owns the object-memory write port
//   level_done       one-cycle pulse when a load completes
//   goals            number of goal fields (types 1, 6, 7) in the loaded level
//   level_error      level validation failure
//   next_screen      one-cycle frame tick to game_logic

module level_loader #(
    parameter int unsigned TICK_DIV = 833333
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  level_sel,
    output logic [8:0]  rom_addr,
    input  logic [10:0] rom_data,
    output logic [6:0]  address_write_om,
    output logic [10:0] data_write_om,
    output logic        wren,
    output logic        busy,
    output logic        level_done,
    output logic [6:0]  goals,
    output logic        level_error,
    output logic        next_screen
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRead   = 3'd1;
    localparam logic [2:0] StPosRow = 3'd2;
    localparam logic [2:0] StPosCol = 3'd3;
    localparam logic [2:0] StCheck  = 3'd4;
    localparam logic [2:0] StRun    = 3'd5;

    // Source of the write data currently on the object-memory port
    localparam logic [1:0] SrcNone = 2'd0;
    localparam logic [1:0] SrcRom  = 2'd1;
    localparam logic [1:0] SrcRow  = 2'd2;
    localparam logic [1:0] SrcCol  = 2'd3;

    localparam logic [6:0]  NumFields = 7'd100;
    localparam logic [6:0]  AddrRow   = 7'd100;
    localparam logic [6:0]  AddrCol   = 7'd101;
    localparam logic [6:0]  AddrPark  = 7'd120;
    localparam logic [3:0]  LastCol   = 4'd9;
    localparam logic [19:0] TickLast  = 20'(TICK_DIV - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  lvl_q, lvl_d;
    logic [6:0]  idx_q, idx_d;
    logic [8:0]  rom_addr_q, rom_addr_d;
    logic        wren_q, wren_d;
    logic [6:0]  waddr_q, waddr_d;
    logic [1:0]  src_q, src_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [6:0]  goals_q, goals_d;
    logic [6:0]  goal_cnt_q, goal_cnt_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [3:0]  cow_row_q, cow_row_d;
    logic [3:0]  cow_col_q, cow_col_d;
    logic [19:0] tick_q, tick_d;
    logic        tick_out_q, tick_out_d;
`ifdef LEVEL_CHECK_EN
    logic [6:0]  box_cnt_q, box_cnt_d;
    logic [6:0]  cow_cnt_q, cow_cnt_d;
    logic        error_q, error_d;
`endif

    logic [2:0] fld_type;
    logic       fld_valid;
    logic       load_req;

    assign fld_type  = rom_data[10:8];
    // The ROM word on the bus belongs to the field being written right now
    assign fld_valid = wren_q && (src_q == SrcRom);
    assign load_req  = start && ((state_q == StIdle) || (state_q == StRun));

    always_comb begin
        state_d    = state_q;
        lvl_d      = lvl_q;
        idx_d      = idx_q;
        rom_addr_d = rom_addr_q;
        wren_d     = wren_q;
        waddr_d    = waddr_q;
        src_d      = src_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        goals_d    = goals_q;
        goal_cnt_d = goal_cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        cow_row_d  = cow_row_q;
        cow_col_d  = cow_col_q;
        tick_d     = tick_q;
        tick_out_d = 1'b0;
`ifdef LEVEL_CHECK_EN
        box_cnt_d  = box_cnt_q;
        cow_cnt_d  = cow_cnt_q;
        error_d    = error_q;
`endif

        // Field scan, one field per written ROM word
        if (fld_valid) begin
            if ((fld_type == 3'd4) || (fld_type == 3'd7)) begin
                cow_row_d = row_q;
                cow_col_d = col_q;
`ifdef LEVEL_CHECK_EN
                cow_cnt_d = cow_cnt_q + 7'd1;
`endif
            end
            if ((fld_type == 3'd1) || (fld_type == 3'd6) || (fld_type == 3'd7)) begin
                goal_cnt_d = goal_cnt_q + 7'd1;
            end
`ifdef LEVEL_CHECK_EN
            if ((fld_type == 3'd5) || (fld_type == 3'd6)) begin
                box_cnt_d = box_cnt_q + 7'd1;
            end
`endif
            if (col_q == LastCol) begin
                col_d = 4'd0;
                row_d = row_q + 4'd1;
            end else begin
                col_d = col_q + 4'd1;
            end
        end

        case (state_q)
            StIdle: begin
            end
            StRead: begin
                busy_d = 1'b1;
                if (idx_q < NumFields) begin
                    rom_addr_d = {lvl_q, idx_q};
                    idx_d      = idx_q + 7'd1;
                end
                // The write stage trails the address stage by one cycle
                if (idx_q != 7'd0) begin
                    wren_d  = 1'b1;
                    waddr_d = idx_q - 7'd1;
                    src_d   = SrcRom;
                end
                if (idx_q == NumFields) begin
                    state_d = StPosRow;
                end
            end
            StPosRow: begin
                wren_d  = 1'b1;
                waddr_d = AddrRow;
                src_d   = SrcRow;
                state_d = StPosCol;
            end
            StPosCol: begin
                wren_d  = 1'b1;
                waddr_d = AddrCol;
                src_d   = SrcCol;
                state_d = StCheck;
            end
            StCheck: begin
                wren_d  = 1'b0;
                waddr_d = AddrPark;
                src_d   = SrcNone;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                goals_d = goal_cnt_q;
`ifdef LEVEL_CHECK_EN
                error_d = (cow_cnt_q != 7'd1) || (box_cnt_q != goal_cnt_q);
`endif
                tick_d  = 20'd0;
                state_d = StRun;
            end
            StRun: begin
                if (tick_q == TickLast) begin
                    tick_d     = 20'd0;
                    tick_out_d = ~level_error;
                end else begin
                    tick_d = tick_q + 20'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A (re)load request overrides the run-state tick on the same cycle
        if (load_req) begin
            state_d    = StRead;
            lvl_d      = level_sel;
            idx_d      = 7'd0;
            goal_cnt_d = 7'd0;
            row_d      = 4'd0;
            col_d      = 4'd0;
            cow_row_d  = 4'd0;
            cow_col_d  = 4'd0;
            tick_d     = 20'd0;
            tick_out_d = 1'b0;
`ifdef LEVEL_CHECK_EN
            box_cnt_d  = 7'd0;
            cow_cnt_d  = 7'd0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lvl_q      <= 2'd0;
            idx_q      <= 7'd0;
            rom_addr_q <= 9'd0;
            wren_q     <= 1'b0;
            waddr_q    <= AddrPark;
            src_q      <= SrcNone;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            goals_q    <= 7'd0;
            goal_cnt_q <= 7'd0;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            cow_row_q  <= 4'd0;
            cow_col_q  <= 4'd0;
            tick_q     <= 20'd0;
            tick_out_q <= 1'b0;
`ifdef LEVEL_CHECK_EN
            box_cnt_q  <= 7'd0;
            cow_cnt_q  <= 7'd0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            idx_q      <= idx_d;
            rom_addr_q <= rom_addr_d;
            wren_q     <= wren_d;
            waddr_q    <= waddr_d;
            src_q      <= src_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            goals_q    <= goals_d;
            goal_cnt_q <= goal_cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cow_row_q  <= cow_row_d;
            cow_col_q  <= cow_col_d;
            tick_q     <= tick_d;
            tick_out_q <= tick_out_d;
`ifdef LEVEL_CHECK_EN
            box_cnt_q  <= box_cnt_d;
            cow_cnt_q  <= cow_cnt_d;
            error_q    <= error_d;
`endif
        end
    end

    // Field words pass straight from the ROM bus; position words come from
    // the scan registers, which already include the last field by then.
    always_comb begin
        data_write_om = 11'd0;
        case (src_q)
            SrcRom:  data_write_om = rom_data;
            SrcRow:  data_write_om = {7'd0, cow_row_q};
            SrcCol:  data_write_om = {7'd0, cow_col_q};
            default: data_write_om = 11'd0;
        endcase
    end

`ifdef LEVEL_CHECK_EN
    assign level_error = error_q;
`else
    assign level_error = 1'b0;
`endif

    assign rom_addr         = rom_addr_q;
    assign address_write_om = waddr_q;
    assign wren             = wren_q;
    assign busy             = busy_q;
    assign level_done       = done_q;
    assign goals            = goals_q;
    assign next_screen      = tick_out_q;

endmodule

// File: tb/tb_level_loader.sv
// Testbench for level_loader (TICK_DIV = 4). A behavioural ROM holds four
// levels; the expected object-memory write stream is queued when each start
// is driven and checked cycle by cycle as the DUT writes.
// Build with or without LEVEL_CHECK_EN; the expected level_error follows.

module tb_level_loader;

    localparam int unsigned TD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic [1:0]  level_sel = 2'd0;
    logic [8:0]  rom_addr;
    logic [10:0] rom_data;
    logic [6:0]  address_write_om;
    logic [10:0] data_write_om;
    logic        wren;
    logic        busy;
    logic        level_done;
    logic [6:0]  goals;
    logic        level_error;
    logic        next_screen;

    level_loader #(.TICK_DIV(TD)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .level_sel        (level_sel),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .address_write_om (address_write_om),
        .data_write_om    (data_write_om),
        .wren             (wren),
        .busy             (busy),
        .level_done       (level_done),
        .goals            (goals),
        .level_error      (level_error),
        .next_screen      (next_screen)
    );

    always #5 clk = ~clk;

    logic [10:0] rom [512];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [6:0]  a;
        logic [10:0] d;
    } wr_t;
    wr_t exp_q[$];

    // Model of the current load
    int         load_s = -1;
    logic [1:0] ld_lvl = 2'd0;
    logic [6:0] ld_goals = 7'd0;
    logic       ld_err = 1'b0;
    logic [6:0] exp_goals = 7'd0;
    logic       exp_err = 1'b0;
    bit         tick_run = 1'b0;
    int         tick_base = 0;
    int         tick_stop = 0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    endtask

    task automatic put(input int lvl, input int idx, input logic [2:0] typ);
        rom[lvl*128 + idx] = {typ, 8'($urandom_range(0, 255))};
    endtask

    task automatic analyse(input logic [1:0] lvl, output logic [6:0] g, output logic e,
                           output logic [10:0] row, output logic [10:0] col);
        int cows = 0, boxes = 0, gl = 0;
        row = 11'd0;
        col = 11'd0;
        for (int i = 0; i < 100; i++) begin
            logic [10:0] w;
            w = rom[{lvl, 7'(i)}];
            if (w[10:8] == 3'd4 || w[10:8] == 3'd7) begin
                cows++;
                row = 11'(i / 10);
                col = 11'(i % 10);
            end
            if (w[10:8] == 3'd1 || w[10:8] == 3'd6 || w[10:8] == 3'd7) gl++;
            if (w[10:8] == 3'd5 || w[10:8] == 3'd6) boxes++;
        end
        g = 7'(gl);
`ifdef LEVEL_CHECK_EN
        e = (cows != 1) || (boxes != gl);
`else
        e = 1'b0;
`endif
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] lvl, output int s);
        logic [10:0] row, col;
        @(negedge clk);
        #1;
        s = cyc + 1;
        analyse(lvl, ld_goals, ld_err, row, col);
        for (int i = 0; i < 100; i++) exp_q.push_back('{s + 2 + i, 7'(i), rom[{lvl, 7'(i)}]});
        exp_q.push_back('{s + 102, 7'd100, row});
        exp_q.push_back('{s + 103, 7'd101, col});
        load_s    = s;
        ld_lvl    = lvl;
        tick_stop = s;
        start     = 1'b1;
        level_sel = lvl;
        @(negedge clk);
        #1;
        start     = 1'b0;
        level_sel = ~lvl;
    endtask

    // Per-cycle monitor, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (load_s >= 0 && cyc == load_s + 104) begin
                exp_goals = ld_goals;
                exp_err   = ld_err;
                tick_run  = !ld_err;
                tick_base = cyc;
                tick_stop = 1 << 30;
            end
            check("busy", busy, load_s >= 0 && cyc >= load_s + 1 && cyc <= load_s + 103);
            check("level_done", level_done, load_s >= 0 && cyc == load_s + 104);
            check("goals", goals, exp_goals);
            check("level_error", level_error, exp_err);
            check("next_screen", next_screen, tick_run && cyc < tick_stop && cyc > tick_base
                  && ((cyc - tick_base) % TD) == 0);
            if (load_s >= 0 && cyc >= load_s + 1 && cyc <= load_s + 100)
                check("rom_addr", rom_addr, {ld_lvl, 7'(cyc - load_s - 1)});
            if (wren) begin
                check("write_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write{cyc,addr,data}", {14'(cyc), address_write_om, data_write_om},
                          {14'(e.c), e.a, e.d});
                end
            end else begin
                check("park_addr", address_write_om, 7'd120);
            end
        end
    end

    initial begin
        int s;
        for (int i = 0; i < 512; i++) rom[i] = {3'd0, 8'($urandom_range(0, 255))};
        // Level 0: walls on row 0, cowboy at 23, three boxes, three goals
        for (int i = 0; i < 10; i++) put(0, i, 3'd2);
        put(0, 23, 3'd4);
        put(0, 34, 3'd5); put(0, 45, 3'd5); put(0, 56, 3'd5);
        put(0, 60, 3'd1); put(0, 70, 3'd1); put(0, 80, 3'd1);
        // Level 1: no cowboy
        put(1, 10, 3'd1); put(1, 11, 3'd1); put(1, 12, 3'd5); put(1, 13, 3'd5);
        // Level 2: cowboy on goal in the last field, box on goal
        put(2, 99, 3'd7); put(2, 50, 3'd6); put(2, 51, 3'd5); put(2, 52, 3'd1);
        put(2, 53, 3'd5);
        // Level 3: two cowboys, last one wins
        put(3, 5, 3'd4); put(3, 77, 3'd4); put(3, 40, 3'd1); put(3, 41, 3'd5);

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_wren", wren, 1'b0);
        check("rst_addr", address_write_om, 7'd120);
        check("rst_rom_addr", rom_addr, 9'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_next_screen", next_screen, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        do_start(2'd0, s);
        wait_to(s + 104 + 14);

        // Reload from RUN; a start in the middle of the load is ignored
        do_start(2'd2, s);
        wait_to(s + 49);
        start     = 1'b1;
        level_sel = 2'd3;
        @(negedge clk);
        #1 start = 1'b0;
        wait_to(s + 104 + 10);

        do_start(2'd1, s);
        wait_to(s + 104 + 20);

        // Asynchronous reset in the middle of a load
        do_start(2'd3, s);
        wait_to(s + 40);
        load_s    = -1;
        exp_q.delete();
        exp_goals = 7'd0;
        exp_err   = 1'b0;
        tick_run  = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("arst_wren", wren, 1'b0);
        check("arst_addr", address_write_om, 7'd120);
        check("arst_data", data_write_om, 11'd0);
        check("arst_busy", busy, 1'b0);
        check("arst_goals", goals, 7'd0);
        check("arst_rom_addr", rom_addr, 9'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        do_start(2'd3, s);
        wait_to(s + 104 + 12);
        do_start(2'd0, s);
        wait_to(s + 104 + 14);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
